// File: rtl/mdio_slave_if.sv
// Clause-22 MDIO responder running in the mclk domain: oversamples MDC/MDIO,
// decodes frames for cfg_phy_addr and drives read data. Optional: MDIO_PREAMBLE_SUPPRESS_EN.
module mdio_slave_if #(
    parameter int SYNC_STAGES = 2,
    parameter int PRE_LEN     = 32
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [4:0]  cfg_phy_addr,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_out_en,
    output logic        reg_rd_req,
    output logic        reg_wr_req,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        frame_err
);

    localparam logic [5:0] PRE_MAX = PRE_LEN[5:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_DATA  = 3'd6
    } state_t;

    state_t state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic        sync_mdc;
    logic        sdin;
    logic        mdc_d;
    logic        rise;
    logic        fall;

    logic [5:0]  pre_cnt;
    logic        pre_ok;
    logic [15:0] sr;
    logic        is_read;
    logic        ignore;
    logic        release_pend;
    logic        drive;

    logic        err_fire;
    logic        op_set;
    logic        op_rd;
    logic        phy_done;
    logic        rd_fire;
    logic        wr_fire;
    logic        rd_last;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
            mdc_d     <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_in};
            mdc_d     <= sync_mdc;
        end
    end

    assign sync_mdc = mdc_sync[SYNC_STAGES-1];
    assign sdin     = mdio_sync[SYNC_STAGES-1];
    assign rise     = sync_mdc & ~mdc_d;
    assign fall     = ~sync_mdc & mdc_d;
    assign drive    = is_read & ~ignore;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign pre_ok = (pre_cnt != 6'd0);
`else
    assign pre_ok = (pre_cnt == PRE_MAX);
`endif

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bit_cnt <= 4'd0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    // Frame decode advances only on sampled MDC rises; bit_cnt counts rises within a field.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        err_fire  = 1'b0;
        op_set    = 1'b0;
        op_rd     = 1'b0;
        phy_done  = 1'b0;
        rd_fire   = 1'b0;
        wr_fire   = 1'b0;
        rd_last   = 1'b0;
        if (rise) begin
            case (state)
                S_IDLE: begin
                    bit_cnt_n = 4'd0;
                    if (!sdin && pre_ok) state_n = S_ST;
                end
                S_ST: begin
                    bit_cnt_n = 4'd0;
                    if (sdin) begin
                        state_n = S_OP;
                    end else begin
                        err_fire = 1'b1;
                        state_n  = S_IDLE;
                    end
                end
                S_OP: begin
                    if (bit_cnt == 4'd0) begin
                        bit_cnt_n = 4'd1;
                    end else begin
                        bit_cnt_n = 4'd0;
                        if ({sr[0], sdin} == 2'b10) begin
                            op_set  = 1'b1;
                            op_rd   = 1'b1;
                            state_n = S_PHYAD;
                        end else if ({sr[0], sdin} == 2'b01) begin
                            op_set  = 1'b1;
                            state_n = S_PHYAD;
                        end else begin
                            err_fire = 1'b1;
                            state_n  = S_IDLE;
                        end
                    end
                end
                S_PHYAD: begin
                    if (bit_cnt == 4'd4) begin
                        phy_done  = 1'b1;
                        bit_cnt_n = 4'd0;
                        state_n   = S_REGAD;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                S_REGAD: begin
                    if (bit_cnt == 4'd4) begin
                        rd_fire   = is_read & ~ignore;
                        bit_cnt_n = 4'd0;
                        state_n   = S_TA;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt == 4'd1) begin
                        bit_cnt_n = 4'd0;
                        state_n   = S_DATA;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == 4'd15) begin
                        wr_fire   = ~is_read & ~ignore;
                        rd_last   = is_read & ~ignore;
                        bit_cnt_n = 4'd0;
                        state_n   = S_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                default: begin
                    bit_cnt_n = 4'd0;
                    state_n   = S_IDLE;
                end
            endcase
        end
    end

    // sr collects OP/PHYAD/write bits on rises and shifts read data out on falls.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            mdio_out     <= 1'b0;
            mdio_out_en  <= 1'b0;
            reg_rd_req   <= 1'b0;
            reg_wr_req   <= 1'b0;
            reg_addr     <= 5'd0;
            reg_wdata    <= 16'd0;
            frame_err    <= 1'b0;
            pre_cnt      <= 6'd0;
            sr           <= 16'd0;
            is_read      <= 1'b0;
            ignore       <= 1'b0;
            release_pend <= 1'b0;
        end else begin
            reg_rd_req <= rd_fire;
            reg_wr_req <= wr_fire;
            frame_err  <= err_fire;

            if (state != S_IDLE) begin
                pre_cnt <= 6'd0;
            end else if (rise) begin
                if (!sdin) begin
                    pre_cnt <= 6'd0;
                end else if (pre_cnt != PRE_MAX) begin
                    pre_cnt <= pre_cnt + 6'd1;
                end
            end

            if (rise) begin
                if (state == S_OP || state == S_PHYAD || (state == S_DATA && !is_read))
                    sr <= {sr[14:0], sdin};
                if (op_set)
                    is_read <= op_rd;
                if (phy_done)
                    ignore <= ({sr[3:0], sdin} != cfg_phy_addr);
                if (state == S_REGAD)
                    reg_addr <= {reg_addr[3:0], sdin};
                if (wr_fire)
                    reg_wdata <= {sr[14:0], sdin};
                if (rd_last)
                    release_pend <= 1'b1;
            end else if (fall) begin
                if (release_pend) begin
                    mdio_out_en  <= 1'b0;
                    mdio_out     <= 1'b0;
                    release_pend <= 1'b0;
                end else if (drive && state == S_TA && bit_cnt == 4'd1) begin
                    sr          <= reg_rdata;
                    mdio_out_en <= 1'b1;
                    mdio_out    <= 1'b0;
                end else if (drive && state == S_DATA) begin
                    mdio_out <= sr[15];
                    sr       <= {sr[14:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_slave_if.sv
// Bench for mdio_slave_if: a bit-level MDIO master replays a table of frames,
// a request scoreboard checks reg_rd_req/reg_wr_req, plus a mid-frame reset sequence.
module tb_mdio_slave_if;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  cfg_phy_addr = 5'd1;
    logic        mdc = 1'b1;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_out_en;
    logic        reg_rd_req;
    logic        reg_wr_req;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = 16'h0;
    logic        frame_err;

    logic master_en  = 1'b1;
    logic master_val = 1'b1;

    // Open-drain style line: DUT drive wins, else master, else pull-up.
    assign mdio_in = mdio_out_en ? mdio_out : (master_en ? master_val : 1'b1);

    mdio_slave_if dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .cfg_phy_addr (cfg_phy_addr),
        .mdc          (mdc),
        .mdio_in      (mdio_in),
        .mdio_out     (mdio_out),
        .mdio_out_en  (mdio_out_en),
        .reg_rd_req   (reg_rd_req),
        .reg_wr_req   (reg_wr_req),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .frame_err    (frame_err)
    );

    always #5 mclk = ~mclk;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    logic [21:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] data;
        logic [4:0]  cfg;
        int          pre;
        logic        exp_req;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Request scoreboard: every request pulse must match the head of exp_q.
    always @(negedge mclk) begin
        logic [21:0] act;
        logic [21:0] e;
        if (reg_rd_req || reg_wr_req) begin
            act = {reg_wr_req, reg_addr, (reg_wr_req ? reg_wdata : 16'h0)};
            checks++;
            if (reg_rd_req && reg_wr_req) begin
                failures++;
                $display("FAIL req_both actual=%h", act);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL req_unexpected actual=%h expected=none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL req_match actual=%h expected=%h", act, e);
                end
            end
        end
        if (frame_err) err_cnt++;
    end

    // One MDC period: fall, master sets line, sample just before the rise.
    task automatic mdc_bit(input logic drv, input logic b, output logic seen, output logic en);
        mdc        = 1'b0;
        master_en  = drv;
        master_val = b;
        #80;
        seen = mdio_in;
        en   = mdio_out_en;
        mdc  = 1'b1;
        #80;
    endtask

    task automatic send_frame(input vec_t v, output logic [16:0] rd_bits,
                              output logic en_all, output logic en_any);
        logic s, e;
        en_all  = 1'b1;
        en_any  = 1'b0;
        rd_bits = 17'h0;
        for (int i = 0; i < v.pre; i++) begin
            mdc_bit(1'b1, 1'b1, s, e);
            en_any |= e;
        end
        mdc_bit(1'b1, 1'b0, s, e);
        mdc_bit(1'b1, 1'b1, s, e);
        mdc_bit(1'b1, v.op[1], s, e);
        mdc_bit(1'b1, v.op[0], s, e);
        if (v.op == 2'b10 || v.op == 2'b01) begin
            for (int i = 4; i >= 0; i--) begin
                mdc_bit(1'b1, v.phy[i], s, e);
                en_any |= e;
            end
            for (int i = 4; i >= 0; i--) begin
                mdc_bit(1'b1, v.regad[i], s, e);
                en_any |= e;
            end
            if (v.op == 2'b10) begin
                mdc_bit(1'b0, 1'b1, s, e);
                en_any |= e;
                mdc_bit(1'b0, 1'b1, s, e);
                rd_bits[16] = s;
                en_all &= e;
                en_any |= e;
                for (int i = 15; i >= 0; i--) begin
                    mdc_bit(1'b0, 1'b1, s, e);
                    rd_bits[i] = s;
                    en_all &= e;
                    en_any |= e;
                end
            end else begin
                mdc_bit(1'b1, 1'b1, s, e);
                en_any |= e;
                mdc_bit(1'b1, 1'b0, s, e);
                en_any |= e;
                for (int i = 15; i >= 0; i--) begin
                    mdc_bit(1'b1, v.data[i], s, e);
                    en_any |= e;
                end
            end
        end
        // Trailing MDC period gives the DUT the fall on which it releases the line.
        mdc_bit(1'b1, 1'b1, s, e);
        master_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [16:0] rd_bits;
        logic        en_all, en_any;
        logic        matched_rd;
        logic        s, e;
        logic [7:0]  part;
        int          err_before;

        //        op     phy    regad  data      cfg    pre exp_req exp_err
        vecs[0]  = '{2'b01, 5'd1,  5'd4,  16'hA5C3, 5'd1,  32, 1'b1, 1'b0};
        vecs[1]  = '{2'b10, 5'd1,  5'h1F, 16'h1234, 5'd1,  32, 1'b1, 1'b0};
        vecs[2]  = '{2'b10, 5'd2,  5'd7,  16'h5555, 5'd1,  32, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 5'd1,  5'd3,  16'hBEEF, 5'd1,  32, 1'b1, 1'b0};
        vecs[4]  = '{2'b11, 5'd1,  5'd2,  16'h0F0F, 5'd1,  32, 1'b0, 1'b1};
        vecs[5]  = '{2'b01, 5'd1,  5'h10, 16'h5A5A, 5'd1,  32, 1'b1, 1'b0};
        vecs[6]  = '{2'b00, 5'd1,  5'd2,  16'h0F0F, 5'd1,  32, 1'b0, 1'b1};
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        vecs[7]  = '{2'b01, 5'd1,  5'd9,  16'h6C1E, 5'd1,  20, 1'b1, 1'b0};
`else
        vecs[7]  = '{2'b01, 5'd1,  5'd9,  16'h6C1E, 5'd1,  20, 1'b0, 1'b0};
`endif
        vecs[8]  = '{2'b01, 5'h1A, 5'h0A, 16'h0001, 5'h1A, 32, 1'b1, 1'b0};
        vecs[9]  = '{2'b10, 5'h1A, 5'h00, 16'h8000, 5'h1A, 40, 1'b1, 1'b0};
        vecs[10] = '{2'b01, 5'h00, 5'h0B, 16'h3C3C, 5'h1A, 32, 1'b0, 1'b0};

        // Reset state
        #33;
        chk("reset_outputs", {mdio_out, mdio_out_en, reg_rd_req, reg_wr_req, frame_err,
                              reg_addr, reg_wdata}, 32'h0);
        reset_n = 1'b1;
        #100;
        chk("post_reset_idle", {mdio_out_en, reg_rd_req, reg_wr_req, frame_err}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            cfg_phy_addr = vecs[i].cfg;
            reg_rdata    = vecs[i].data;
            err_before   = err_cnt;
            matched_rd   = (vecs[i].op == 2'b10) && (vecs[i].phy == vecs[i].cfg);
            if (vecs[i].exp_req)
                exp_q.push_back({(vecs[i].op == 2'b01), vecs[i].regad,
                                 ((vecs[i].op == 2'b01) ? vecs[i].data : 16'h0)});
            send_frame(vecs[i], rd_bits, en_all, en_any);
            #200;
            chk($sformatf("v%0d_req_drained", i), exp_q.size(), 0);
            chk($sformatf("v%0d_frame_err", i), err_cnt - err_before, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_en_released", i), {mdio_out_en, mdio_out}, 0);
            if (matched_rd) begin
                chk($sformatf("v%0d_rd_bits", i), rd_bits, {1'b0, vecs[i].data});
                chk($sformatf("v%0d_en_window", i), en_all, 1);
            end else begin
                chk($sformatf("v%0d_no_drive", i), en_any, 0);
                if (vecs[i].op == 2'b10)
                    chk($sformatf("v%0d_rd_bits_pullup", i), rd_bits, 17'h1FFFF);
            end
            exp_q.delete();
        end

        // Reset during the read data phase, after 8 data bits.
        cfg_phy_addr = 5'd1;
        reg_rdata    = 16'hC3A5;
        exp_q.push_back({1'b0, 5'd5, 16'h0});
        for (int i = 0; i < 32; i++) mdc_bit(1'b1, 1'b1, s, e);
        mdc_bit(1'b1, 1'b0, s, e);
        mdc_bit(1'b1, 1'b1, s, e);
        mdc_bit(1'b1, 1'b1, s, e);
        mdc_bit(1'b1, 1'b0, s, e);
        for (int i = 4; i >= 0; i--) mdc_bit(1'b1, (i == 0), s, e);
        for (int i = 4; i >= 0; i--) mdc_bit(1'b1, (i == 2 || i == 0), s, e);
        mdc_bit(1'b0, 1'b1, s, e);
        mdc_bit(1'b0, 1'b1, s, e);
        for (int i = 7; i >= 0; i--) begin
            mdc_bit(1'b0, 1'b1, s, e);
            part[i] = s;
        end
        chk("rst_partial_bits", part, 8'hC3);
        chk("rst_en_before", mdio_out_en, 1);
        mdc = 1'b0;
        #30;
        reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", {mdio_out, mdio_out_en, reg_rd_req, reg_wr_req, frame_err,
                                  reg_addr, reg_wdata}, 32'h0);
        #100;
        mdc       = 1'b1;
        master_en = 1'b1;
        #100;
        reset_n = 1'b1;
        #200;
        chk("rst_req_count", exp_q.size(), 0);
        exp_q.delete();

        reg_rdata = 16'h0F1E;
        exp_q.push_back({1'b0, 5'h15, 16'h0});
        send_frame('{2'b10, 5'd1, 5'h15, 16'h0F1E, 5'd1, 32, 1'b1, 1'b0}, rd_bits, en_all, en_any);
        #200;
        chk("rst_after_req_drained", exp_q.size(), 0);
        chk("rst_after_rd_bits", rd_bits, {1'b0, 16'h0F1E});
        chk("rst_after_en_window", en_all, 1);
        chk("rst_after_en_released", mdio_out_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
